// File: rtl/dcache_wb_burst_ctrl.sv
// dcache_wb_burst_ctrl: writes one evicted D-cache line to memory as a single
// AXI-style INCR write burst (one AW beat, NBEAT W beats, one B response).
module dcache_wb_burst_ctrl #(
  parameter int Offset_len    = 6,
  parameter int Segment_width = 32,
  parameter int Addr_width    = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          wb_req,
  input  logic [Addr_width-1:0]         wb_addr,
  input  logic [(1<<(Offset_len+3))-1:0] wb_line,
  output logic                          wb_ready,
  output logic                          wb_done,
  output logic                          wb_err,
  output logic                          awvalid,
  output logic [Addr_width-1:0]         awaddr,
  output logic [7:0]                    awlen,
  input  logic                          awready,
  output logic                          wvalid,
  output logic [Segment_width-1:0]      wdata,
  output logic                          wlast,
  input  logic                          wready,
  input  logic                          bvalid,
  input  logic [1:0]                    bresp,
  output logic                          bready,
  output logic [Offset_len-2:0]         buf_shift_count,
  output logic [(1<<(Offset_len+3))-1:0] d_wdata,
  input  logic [Segment_width-1:0]      write_data_mux
);
  localparam int LW = 1 << (Offset_len + 3);
  localparam int CW = Offset_len - 2;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  logic [1:0]            state;
  logic [LW-1:0]         line_q;
  logic [Addr_width-1:0] addr_q;
  logic [CW-1:0]         cnt;
  logic                  done_q;
  logic                  err_q;
  logic                  unused_addr_lsb;
  // The line offset bits never reach the bus: bursts are always line-aligned.
  assign unused_addr_lsb = ^wb_addr[Offset_len-1:0];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      line_q <= '0;
      addr_q <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (wb_req) begin
          line_q <= wb_line;
          addr_q <= {wb_addr[Addr_width-1:Offset_len], {Offset_len{1'b0}}};
          cnt    <= '0;
          state  <= ADDR;
        end
        ADDR: if (awready) state <= DATA;
        DATA: if (wready) begin
          if (wlast) state <= RESP;
          else cnt <= cnt + 1'b1;
        end
        default: if (bvalid) begin
          done_q <= 1'b1;
          err_q  <= |bresp;
          state  <= IDLE;
        end
      endcase
    end
  end
  assign wb_ready        = state == IDLE;
  assign wb_done         = done_q;
  assign wb_err          = err_q && done_q;
  assign awvalid         = state == ADDR;
  assign awaddr          = addr_q;
  assign awlen           = 8'((1 << CW) - 1);
  assign wvalid          = state == DATA;
  assign wdata           = write_data_mux;
  assign wlast           = wvalid && (cnt == '1);
  assign bready          = state == RESP;
  assign buf_shift_count = {1'b0, cnt};
  assign d_wdata         = line_q;
endmodule
